// File: rtl/key_action_decoder.sv
// Keycode-to-action decoder: matches the USB keycode slots against a keymap once per frame tick.
// For each action it produces a held level, press/release pulses and a typematic repeat pulse.
// `release` is a reserved word, so the release pulse port is named release_p.
module key_action_decoder #(
  parameter int unsigned                  NUM_SLOTS    = 6,
  parameter int unsigned                  NUM_ACTIONS  = 8,
  parameter logic [8*NUM_ACTIONS-1:0]     KEYMAP       = 64'h51_52_4F_50_16_1A_07_04,
  parameter int unsigned                  REPEAT_DELAY = 30,
  parameter int unsigned                  REPEAT_RATE  = 6
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     frame_tick,
  input  logic                     enable,
  input  logic [8*NUM_SLOTS-1:0]   keycodes,
  output logic [NUM_ACTIONS-1:0]   held,
  output logic [NUM_ACTIONS-1:0]   press,
  output logic [NUM_ACTIONS-1:0]   release_p,
  output logic [NUM_ACTIONS-1:0]   repeat_p
);

  localparam int unsigned CntW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int unsigned CntTotW = CntW * NUM_ACTIONS;
  localparam logic [CntW-1:0] CntReload = CntW'(REPEAT_DELAY - REPEAT_RATE);

  logic [NUM_ACTIONS-1:0] match;
  logic [NUM_ACTIONS-1:0] held_d, held_q;
  logic [NUM_ACTIONS-1:0] press_d, press_q;
  logic [NUM_ACTIONS-1:0] release_d, release_q;
  logic [NUM_ACTIONS-1:0] repeat_d, repeat_q;
  logic [CntTotW-1:0]     cnt_d, cnt_q;

  // An all-zero keymap entry is unmapped and must never match an empty slot.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (enable && (KEYMAP[8*i +: 8] != 8'h00) &&
            (keycodes[8*k +: 8] == KEYMAP[8*i +: 8])) begin
          match[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    held_d    = held_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    cnt_d     = cnt_q;
    if (frame_tick) begin
      held_d    = match;
      press_d   = match & ~held_q;
      release_d = ~match & held_q;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
        if (REPEAT_DELAY == 0) begin
          cnt_d[i*CntW +: CntW] = '0;
        end else if (!match[i] || !held_q[i]) begin
          // Release and fresh press both restart the typematic delay.
          cnt_d[i*CntW +: CntW] = '0;
        end else if ((32'(cnt_q[i*CntW +: CntW]) + 32'd1) == REPEAT_DELAY) begin
          repeat_d[i]           = 1'b1;
          cnt_d[i*CntW +: CntW] = CntReload;
        end else begin
          cnt_d[i*CntW +: CntW] = cnt_q[i*CntW +: CntW] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      held_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      cnt_q     <= '0;
    end else begin
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign held      = held_q;
  assign press     = press_q;
  assign release_p = release_q;
  assign repeat_p  = repeat_q;

endmodule

// File: tb/tb_key_action_decoder.sv
// Directed bench for key_action_decoder: default, fast-repeat and zero-entry/no-repeat instances
// share one stimulus stream.
module tb_key_action_decoder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic        enable;
  logic [47:0] keycodes;

  logic [7:0] d_held, d_press, d_rel, d_rep;
  logic [7:0] r_held, r_press, r_rel, r_rep;
  logic [7:0] z_held, z_press, z_rel, z_rep;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  key_action_decoder u_def (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable), .keycodes(keycodes),
    .held(d_held), .press(d_press), .release_p(d_rel), .repeat_p(d_rep)
  );

  key_action_decoder #(.REPEAT_DELAY(4), .REPEAT_RATE(2)) u_rep (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable), .keycodes(keycodes),
    .held(r_held), .press(r_press), .release_p(r_rel), .repeat_p(r_rep)
  );

  key_action_decoder #(.KEYMAP(64'h51_52_4F_50_16_00_07_04), .REPEAT_DELAY(0),
                       .REPEAT_RATE(1)) u_zero (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable), .keycodes(keycodes),
    .held(z_held), .press(z_press), .release_p(z_rel), .repeat_p(z_rep)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sampling tick; outputs are observed 1 time unit after the edge.
  task automatic tick(input logic [47:0] kc, input logic en);
    keycodes   = kc;
    enable     = en;
    frame_tick = 1'b1;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic idle(input logic [47:0] kc);
    keycodes   = kc;
    frame_tick = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset      = 1'b1;
    frame_tick = 1'b0;
    enable     = 1'b1;
    keycodes   = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outs", {d_held, d_press, d_rel, d_rep}, 32'h0);
    Reset = 1'b0;
    idle(48'h0);

    // Single press / release of 8'h04
    tick(48'h04, 1'b1);
    chk("sp_press", {d_held, d_press}, {8'h01, 8'h01});
    chk("sp_rel0", d_rel, 8'h00);
    idle(48'h00);
    chk("sp_pulse_width", {d_held, d_press}, {8'h01, 8'h00});
    tick(48'h04, 1'b1);
    tick(48'h04, 1'b1);
    tick(48'h04, 1'b1);
    chk("sp_held_t4", {d_held, d_press, d_rel}, {8'h01, 8'h00, 8'h00});
    tick(48'h00, 1'b1);
    chk("sp_release", {d_held, d_rel}, {8'h00, 8'h01});
    idle(48'h00);
    chk("sp_rel_width", d_rel, 8'h00);

    // Slot placement and duplicates
    tick({8'h1A, 8'h00, 8'h00, 8'h1A, 8'h00, 8'h52}, 1'b1);
    chk("dup_held", d_held, 8'b0100_0100);
    chk("dup_press", d_press, 8'b0100_0100);
    chk("zero_map_dup", z_held, 8'b0100_0000);
    tick({8'h1A, 8'h00, 8'h00, 8'h1A, 8'h00, 8'h52}, 1'b1);
    chk("dup_no_repress", d_press, 8'h00);
    tick(48'h00, 1'b1);
    chk("dup_release", d_rel, 8'b0100_0100);

    // Empty slots never match an unmapped (zero) entry
    tick(48'h00, 1'b1);
    tick(48'h00, 1'b1);
    chk("zero_entry_held", z_held, 8'h00);
    chk("zero_entry_press", z_press, 8'h00);

    // Auto-repeat: delay 4, rate 2
    tick(48'h07, 1'b1);
    chk("rep_press", {r_press, r_rep}, {8'h02, 8'h00});
    for (int t = 1; t <= 12; t++) begin
      tick(48'h07, 1'b1);
      chk($sformatf("rep_t%0d", t), {r_press, r_rep},
          {8'h00, ((t >= 4) && (t % 2 == 0)) ? 8'h02 : 8'h00});
    end
    chk("rep_def_none", d_rep, 8'h00);
    chk("rep_disabled", z_rep, 8'h00);
    idle(48'h07);
    chk("rep_pulse_width", r_rep, 8'h00);
    tick(48'h00, 1'b1);

    // Enable gating of 8'h50 (action 4)
    tick(48'h50, 1'b1);
    chk("gate_press", d_press, 8'h10);
    tick(48'h50, 1'b1);
    tick(48'h50, 1'b1);
    tick(48'h50, 1'b0);
    chk("gate_release", {d_held, d_rel}, {8'h00, 8'h10});
    tick(48'h50, 1'b0);
    tick(48'h50, 1'b0);
    chk("gate_off_held", {d_held, d_rel, d_press}, 24'h0);
    tick(48'h50, 1'b1);
    chk("gate_repress", {d_held, d_press}, {8'h10, 8'h10});
    tick(48'h00, 1'b1);

    // Async reset mid-hold of 8'h16 (action 3)
    tick(48'h16, 1'b1);
    tick(48'h16, 1'b1);
    tick(48'h16, 1'b1);
    tick(48'h16, 1'b1);
    chk("ar_held_before", {d_held, r_held}, {8'h08, 8'h08});
    Reset = 1'b1;
    #1;
    chk("ar_async_clear", {d_held, r_held, d_press, r_rep}, 32'h0);
    Reset = 1'b0;
    #1;
    tick(48'h16, 1'b1);
    chk("ar_repress", {d_held, d_press}, {8'h08, 8'h08});
    for (int t = 1; t <= 4; t++) begin
      tick(48'h16, 1'b1);
      chk($sformatf("ar_rep_t%0d", t), r_rep, (t == 4) ? 8'h08 : 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_action_decoder.md
# key_action_decoder

Parametrised keycode-to-action decoder between the USB keyboard keycode register and the character/game-logic blocks. It scans NUM_SLOTS concurrent keycodes against a NUM_ACTIONS-entry keymap once per frame tick. Per action it emits a level (held), single-cycle press/release edge pulses and a typematic auto-repeat pulse. Game FSMs thereby get clean per-frame events instead of raw key levels.

## Interface
Parameters:
- NUM_SLOTS, 6, number of 8-bit keycode slots in `keycodes`
- NUM_ACTIONS, 8, number of mapped actions
- KEYMAP, 64'h51_52_4F_50_16_1A_07_04, packed 8*NUM_ACTIONS keycodes; action i = KEYMAP[8*i+7:8*i]; default order is P1 left, right, attack, defense, then P2 left, right, attack, defense
- REPEAT_DELAY, 30, frame ticks from press to first repeat; 0 disables repeat
- REPEAT_RATE, 6, frame ticks between subsequent repeats; legal range 1..REPEAT_DELAY

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-Clk-cycle sampling strobe, once per video frame
- enable  in  1  0 = treat all keys as released
- keycodes  in  8*NUM_SLOTS  slot k = keycodes[8*k+7:8*k]; 8'h00 = empty slot
- held  out  NUM_ACTIONS  registered action level
- press  out  NUM_ACTIONS  one-cycle pulse on 0->1 of held
- release  out  NUM_ACTIONS  one-cycle pulse on 1->0 of held
- repeat_p  out  NUM_ACTIONS  one-cycle auto-repeat pulse

## Operation
- Match: match[i] = enable && (KEYMAP entry i != 8'h00) && any slot == entry i. Keycode 8'h00 never matches. A keycode present in several slots counts once. Several actions mapped to the same keycode all match.
- All state updates only on cycles with frame_tick = 1. keycodes between ticks are ignored.
- On tick, per action i:
  - held[i] <= match[i]
  - press[i] <= match[i] & ~held[i]
  - release[i] <= ~match[i] & held[i]
- On a non-tick cycle, press, release and repeat_p are all 0. held keeps its value.
- Repeat counter cnt[i] has width clog2(REPEAT_DELAY+1), with a minimum of 1 bit. On each tick:
  - match[i] = 0: cnt <= 0, no repeat.
  - Rising edge (press): cnt <= 0.
  - Held, and cnt+1 == REPEAT_DELAY: repeat_p[i] <= 1, cnt <= REPEAT_DELAY - REPEAT_RATE.
  - Held, otherwise: cnt <= cnt+1.
  - REPEAT_DELAY = 0: repeat_p is tied to 0 and counters are unused.
- press and repeat_p never assert on the same tick for the same action.
- enable low at a tick: every held action releases (release pulse), counters clear. When enable returns, keys still down re-press at the next tick.
- No opposing-direction arbitration. Left and right may both be held. Resolution belongs to the character FSM.

## Timing
- Reset asserted: held, press, release, repeat_p and all counters are 0 immediately (async). Reset release is synchronised to Clk by the top level.
- Latency: a keycode sampled at tick cycle t is reflected in held/press/release/repeat_p at t+1 (registered outputs). Pulses are exactly one Clk cycle wide.
- Back-to-back ticks (frame_tick high on consecutive cycles) are legal. Each cycle is a full sample.
- Reset mid-hold: after deassert held = 0, so a still-pressed key produces press at the first tick, and repeat timing restarts.
- First repeat comes REPEAT_DELAY ticks after the press tick. Later repeats come every REPEAT_RATE ticks.
- A key released and re-pressed between two ticks is invisible, by design.

## Test plan
- Single press/release (defaults): keycodes = 48'h04 at tick 1, 0 at tick 5 -> press[0] at tick1+1; held[0] = 1 over ticks 1-4; release[0] at tick5+1. All other actions stay 0.
- Slot/duplicate: 8'h1A in slot 5 and slot 2, 8'h52 in slot 0 -> held = 8'b0100_0100. Exactly one press per action.
- Auto-repeat with REPEAT_DELAY=4, REPEAT_RATE=2: hold 8'h07 for 12 ticks (press at tick 0) -> repeat_p[1] at ticks 4, 6, 8, 10, 12 (each +1 cycle). No repeat on the press tick.
- Gating: hold 8'h50, drop enable at tick 3, raise it at tick 6 -> release[4] at tick3+1, held[4] = 0 over ticks 3-5, press[4] at tick6+1.
- Async reset mid-hold: hold 8'h16, pulse Reset between ticks -> outputs are 0 within the same cycle. The next tick gives press[3] = 1.
- Zero-entry keymap: KEYMAP entry 2 = 8'h00, all slots empty -> held[2] never asserts.
